// File: rtl/alloc_seq.sv
// Request sequencer in front of the linked-memory allocator.
// Optional: define ALLOC_SEQ_RANGE_CHECK_EN to reject READ/WRITE/FREE outside the heap window.
module alloc_seq #(
    parameter int DATA_SZ   = 16,
    parameter int TAG_SZ    = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [2:0]         i_req_op,
    input  logic [DATA_SZ-1:0] i_req_addr,
    input  logic [DATA_SZ-1:0] i_req_data,
    input  logic [TAG_SZ-1:0]  i_req_tag,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [DATA_SZ-1:0] o_rsp_value,
    output logic [TAG_SZ-1:0]  o_rsp_tag,
    output logic               o_alloc,
    output logic               o_free,
    output logic               o_wr,
    output logic               o_rd,
    output logic [DATA_SZ-1:0] o_data,
    output logic [DATA_SZ-1:0] o_addr,
    output logic [DATA_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic [DATA_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_aaddr,
    input  logic [DATA_SZ-1:0] i_rdata,
    input  logic               i_aerr,
    output logic               o_err
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam logic [AW+1:0] DEPTH_V = (AW+2)'(RSP_DEPTH);

    localparam logic [2:0] OP_RD = 3'b001;
    localparam logic [2:0] OP_WR = 3'b010;
    localparam logic [2:0] OP_AL = 3'b100;
    localparam logic [2:0] OP_FR = 3'b101;
    localparam logic [2:0] OP_AF = 3'b110;

    typedef enum logic {RUN, HALT} state_t;
    typedef enum logic [1:0] {CL_ADDR, CL_DATA, CL_UNIT} cls_t;

    state_t state_q, state_d;
    cls_t   cls_d, cls_q;

    logic legal, chk, range_bad;
    logic accept, go, bad;

    logic              inflight_q;
    logic [TAG_SZ-1:0] tag_q;

    logic [TAG_SZ+DATA_SZ-1:0] fifo [RSP_DEPTH];
    logic [AW-1:0]             head_q, tail_q;
    logic [AW:0]               count_q;
    logic [AW+1:0]             occ;
    logic                      push, pop;
    logic [DATA_SZ-1:0]        push_val;

    // Classify the offered op and decide which result source it needs
    always_comb begin
        legal = 1'b0;
        chk   = 1'b0;
        cls_d = CL_UNIT;
        case (i_req_op)
            OP_RD: begin legal = 1'b1; chk = 1'b1; cls_d = CL_DATA; end
            OP_WR: begin legal = 1'b1; chk = 1'b1; cls_d = CL_UNIT; end
            OP_AL: begin legal = 1'b1; cls_d = CL_ADDR; end
            OP_FR: begin legal = 1'b1; chk = 1'b1; cls_d = CL_UNIT; end
            OP_AF: begin legal = 1'b1; cls_d = CL_ADDR; end
            default: ;
        endcase
    end

`ifdef ALLOC_SEQ_RANGE_CHECK_EN
    assign range_bad = chk && (i_req_addr[DATA_SZ-1 -: 4] != 4'b0101);
`else
    // Addresses are forwarded unchecked
    assign range_bad = chk && 1'b0;
`endif

    // One slot is kept back for the op whose result is still in flight
    assign occ         = (AW+2)'(count_q) + (AW+2)'(inflight_q);
    assign o_req_ready = (state_q == RUN) && (occ < DEPTH_V);
    assign o_err       = (state_q == HALT);

    assign accept = i_req_valid && o_req_ready && !i_rst;
    assign go     = accept && legal && !range_bad;
    assign bad    = accept && !go;

    // Drive exactly one legal strobe set for an issued op
    always_comb begin
        o_alloc = 1'b0;
        o_free  = 1'b0;
        o_wr    = 1'b0;
        o_rd    = 1'b0;
        o_data  = '0;
        o_addr  = '0;
        o_waddr = '0;
        o_wdata = '0;
        o_raddr = '0;
        if (go) begin
            case (i_req_op)
                OP_RD: begin o_rd = 1'b1; o_raddr = i_req_addr; end
                OP_WR: begin
                    o_wr    = 1'b1;
                    o_waddr = i_req_addr;
                    o_wdata = i_req_data;
                end
                OP_AL: begin o_alloc = 1'b1; o_data = i_req_data; end
                OP_FR: begin o_free = 1'b1; o_addr = i_req_addr; end
                OP_AF: begin
                    o_alloc = 1'b1;
                    o_free  = 1'b1;
                    o_data  = i_req_data;
                    o_addr  = i_req_addr;
                end
                default: ;
            endcase
        end
    end

    // Remember class and tag of the op the allocator answers next cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q <= 1'b0;
            cls_q      <= CL_UNIT;
            tag_q      <= '0;
        end else begin
            inflight_q <= go;
            if (go) begin
                cls_q <= cls_d;
                tag_q <= i_req_tag;
            end
        end
    end

    // Select the response value for the captured op
    always_comb begin
        push_val = DATA_SZ'(4);
        case (cls_q)
            CL_ADDR: push_val = i_aaddr;
            CL_DATA: push_val = i_rdata;
            default: push_val = DATA_SZ'(4);
        endcase
    end

    assign push = inflight_q && !i_aerr;
    assign pop  = (count_q != '0) && i_rsp_ready;

    // Response FIFO storage
    always_ff @(posedge i_clk) begin
        if (push)
            fifo[tail_q] <= {tag_q, push_val};
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign o_rsp_valid = (count_q != '0);
    assign {o_rsp_tag, o_rsp_value} = fifo[head_q];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Any illegal op or allocator error halts until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bad || (inflight_q && i_aerr)) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

endmodule
